id_stage_pipe: RTL and testbench

- Parametrised decode stage for the 16-bit pipelined core.
- Decodes one instruction per cycle and resolves branches in ID.
- Detects load-use hazards and inserts a configurable number of bubbles.
- Owns the ID/EX pipeline register, with valid/ready handshakes upstream and downstream and a flush input from later stages.

---
 rtl/id_stage_pipe_pkg.sv | 45 ++++
 rtl/id_decoder.sv | 83 ++++++++
 rtl/id_stage_pipe.sv | 219 +++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pipe_pkg.sv
// Shared widths, opcode/ALU encodings and FSM states for the ID stage of the
// 16-bit pipelined core.
package id_stage_pipe_pkg;

    localparam int WORD_LEN     = 16;
    localparam int REG_ADDR_LEN = 4;
    localparam int IMM_LEN      = 8;
    localparam int EXE_CMD_LEN  = 4;
    localparam int OPCODE_LEN   = 4;

    localparam logic [OPCODE_LEN-1:0] OP_NOP  = 4'd0;
    localparam logic [OPCODE_LEN-1:0] OP_ADD  = 4'd1;
    localparam logic [OPCODE_LEN-1:0] OP_SUB  = 4'd2;
    localparam logic [OPCODE_LEN-1:0] OP_AND  = 4'd3;
    localparam logic [OPCODE_LEN-1:0] OP_OR   = 4'd4;
    localparam logic [OPCODE_LEN-1:0] OP_XOR  = 4'd5;
    localparam logic [OPCODE_LEN-1:0] OP_SLL  = 4'd6;
    localparam logic [OPCODE_LEN-1:0] OP_SRL  = 4'd7;
    localparam logic [OPCODE_LEN-1:0] OP_ADDI = 4'd8;
    localparam logic [OPCODE_LEN-1:0] OP_LD   = 4'd9;
    localparam logic [OPCODE_LEN-1:0] OP_ST   = 4'd10;
    localparam logic [OPCODE_LEN-1:0] OP_BEZ  = 4'd11;
    localparam logic [OPCODE_LEN-1:0] OP_BNE  = 4'd12;
    localparam logic [OPCODE_LEN-1:0] OP_JMP  = 4'd13;

    // ALU commands reuse the register-register opcode values.
    localparam logic [EXE_CMD_LEN-1:0] EXE_NOP = 4'd0;
    localparam logic [EXE_CMD_LEN-1:0] EXE_ADD = 4'd1;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SUB = 4'd2;
    localparam logic [EXE_CMD_LEN-1:0] EXE_AND = 4'd3;
    localparam logic [EXE_CMD_LEN-1:0] EXE_OR  = 4'd4;
    localparam logic [EXE_CMD_LEN-1:0] EXE_XOR = 4'd5;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SLL = 4'd6;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SRL = 4'd7;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    function automatic logic is_alu_reg_op(input logic [OPCODE_LEN-1:0] op);
        return (op >= OP_ADD) && (op <= OP_SRL);
    endfunction

endpackage

// File: rtl/id_decoder.sv
// Combinational opcode to control mapping for the ID stage, including the
// read-port B select (rd field for ST/BNE, rs2 field otherwise).
module id_decoder
    import id_stage_pipe_pkg::*;
(
    input  logic [OPCODE_LEN-1:0]   opcode,
    input  logic [REG_ADDR_LEN-1:0] rd_field,
    input  logic [REG_ADDR_LEN-1:0] rs2_field,
    output logic                    wb_en,
    output logic                    mem_r_en,
    output logic                    mem_w_en,
    output logic                    imm_sel,
    output logic                    use_rs1,
    output logic                    use_rs2,
    output logic                    is_bez,
    output logic                    is_bne,
    output logic                    is_jmp,
    output logic [EXE_CMD_LEN-1:0]  exe_cmd,
    output logic [REG_ADDR_LEN-1:0] src2
);

    always_comb begin
        wb_en    = 1'b0;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        imm_sel  = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        is_bez   = 1'b0;
        is_bne   = 1'b0;
        is_jmp   = 1'b0;
        exe_cmd  = EXE_NOP;
        src2     = rs2_field;

        if (is_alu_reg_op(opcode)) begin
            wb_en   = 1'b1;
            exe_cmd = EXE_CMD_LEN'(opcode);
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
        end else begin
            case (opcode)
                OP_ADDI: begin
                    wb_en   = 1'b1;
                    imm_sel = 1'b1;
                    exe_cmd = EXE_ADD;
                    use_rs1 = 1'b1;
                end
                OP_LD: begin
                    wb_en    = 1'b1;
                    mem_r_en = 1'b1;
                    imm_sel  = 1'b1;
                    exe_cmd  = EXE_ADD;
                    use_rs1  = 1'b1;
                end
                // Store data comes from the rd field through read port B.
                OP_ST: begin
                    mem_w_en = 1'b1;
                    imm_sel  = 1'b1;
                    exe_cmd  = EXE_ADD;
                    use_rs1  = 1'b1;
                    use_rs2  = 1'b1;
                    src2     = rd_field;
                end
                OP_BEZ: begin
                    is_bez  = 1'b1;
                    use_rs1 = 1'b1;
                end
                OP_BNE: begin
                    is_bne  = 1'b1;
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                    src2    = rd_field;
                end
                OP_JMP: begin
                    is_jmp = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: decodes and resolves branches, inserts load-use bubbles and
// owns the ID/EX register with valid/ready handshakes on both sides.
module id_stage_pipe #(
    parameter int WORD_LEN     = 16,
    parameter int REG_ADDR_LEN = 4,
    parameter int IMM_LEN      = 8,
    parameter int EXE_CMD_LEN  = 4,
    parameter int LOAD_DELAY   = 1,
    parameter int CNT_LEN      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORD_LEN-1:0]     instruction,
    output logic [REG_ADDR_LEN-1:0] src1,
    output logic [REG_ADDR_LEN-1:0] src2,
    input  logic [WORD_LEN-1:0]     reg1,
    input  logic [WORD_LEN-1:0]     reg2,
    output logic                    br_taken,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_LEN-1:0]     out_val1,
    output logic [WORD_LEN-1:0]     out_val2,
    output logic [WORD_LEN-1:0]     out_st_val,
    output logic [REG_ADDR_LEN-1:0] out_dest,
    output logic [REG_ADDR_LEN-1:0] out_src1,
    output logic [REG_ADDR_LEN-1:0] out_src2_forw,
    output logic [EXE_CMD_LEN-1:0]  out_exe_cmd,
    output logic                    out_mem_r_en,
    output logic                    out_mem_w_en,
    output logic                    out_wb_en,
    output logic [CNT_LEN-1:0]      stall_cnt
);

    import id_stage_pipe_pkg::*;

    localparam logic [2:0] DELAY_M1 = 3'(LOAD_DELAY - 1);

    logic [OPCODE_LEN-1:0]   opcode;
    logic [REG_ADDR_LEN-1:0] rd_field;
    logic [REG_ADDR_LEN-1:0] rs2_field;
    logic [IMM_LEN-1:0]      imm_field;
    logic [WORD_LEN-1:0]     imm_ext;

    logic                    dec_wb_en;
    logic                    dec_mem_r_en;
    logic                    dec_mem_w_en;
    logic                    dec_imm_sel;
    logic                    dec_use_rs1;
    logic                    dec_use_rs2;
    logic                    dec_is_bez;
    logic                    dec_is_bne;
    logic                    dec_is_jmp;
    logic [EXE_CMD_LEN-1:0]  dec_exe_cmd;

    state_t                  state;
    state_t                  state_next;
    logic [2:0]              bubble_cnt;
    logic [2:0]              bubble_cnt_next;

    logic                    out_free;
    logic                    hazard;
    logic                    accept;
    logic                    br_cond;

    logic                    entry_valid;
    logic [WORD_LEN-1:0]     entry_val1;
    logic [WORD_LEN-1:0]     entry_val2;
    logic [WORD_LEN-1:0]     entry_st_val;
    logic [REG_ADDR_LEN-1:0] entry_dest;
    logic [REG_ADDR_LEN-1:0] entry_src1;
    logic [REG_ADDR_LEN-1:0] entry_src2_forw;
    logic [EXE_CMD_LEN-1:0]  entry_exe_cmd;
    logic                    entry_mem_r_en;
    logic                    entry_mem_w_en;
    logic                    entry_wb_en;

    assign opcode    = instruction[12 +: OPCODE_LEN];
    assign rd_field  = instruction[8 +: REG_ADDR_LEN];
    assign rs2_field = instruction[4 +: REG_ADDR_LEN];
    assign imm_field = instruction[IMM_LEN-1:0];
    assign imm_ext   = {{(WORD_LEN-IMM_LEN){imm_field[IMM_LEN-1]}}, imm_field};
    assign src1      = rd_field;

    id_decoder u_decoder (
        .opcode    (opcode),
        .rd_field  (rd_field),
        .rs2_field (rs2_field),
        .wb_en     (dec_wb_en),
        .mem_r_en  (dec_mem_r_en),
        .mem_w_en  (dec_mem_w_en),
        .imm_sel   (dec_imm_sel),
        .use_rs1   (dec_use_rs1),
        .use_rs2   (dec_use_rs2),
        .is_bez    (dec_is_bez),
        .is_bne    (dec_is_bne),
        .is_jmp    (dec_is_jmp),
        .exe_cmd   (dec_exe_cmd),
        .src2      (src2)
    );

    // A load in ID/EX whose destination feeds this instruction must wait.
    assign out_free = !out_valid || out_ready;
    assign hazard   = in_valid && out_valid && out_mem_r_en &&
                      ((dec_use_rs1 && (out_dest == src1)) ||
                       (dec_use_rs2 && (out_dest == src2)));
    assign in_ready = (state == ST_RUN) && !hazard && out_free;
    assign accept   = in_valid && in_ready;
    assign br_cond  = dec_is_jmp ||
                      (dec_is_bez && (reg1 == '0)) ||
                      (dec_is_bne && (reg1 != reg2));
    assign br_taken = accept && br_cond;

    // The hazard cycle already emits the first bubble, so STALL only
    // covers the remaining LOAD_DELAY-1 bubbles (none when LOAD_DELAY=1).
    always_comb begin
        state_next      = state;
        bubble_cnt_next = bubble_cnt;
        case (state)
            ST_RUN: begin
                if (hazard && out_free && (LOAD_DELAY > 1)) begin
                    state_next      = ST_STALL;
                    bubble_cnt_next = DELAY_M1;
                end
            end
            ST_STALL: begin
                if (out_ready) begin
                    if (bubble_cnt <= 3'd1) begin
                        state_next      = ST_RUN;
                        bubble_cnt_next = 3'd0;
                    end else begin
                        bubble_cnt_next = bubble_cnt - 3'd1;
                    end
                end
            end
            default: begin
                state_next      = ST_RUN;
                bubble_cnt_next = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state      <= ST_RUN;
            bubble_cnt <= 3'd0;
        end else begin
            state      <= state_next;
            bubble_cnt <= bubble_cnt_next;
        end
    end

    always_comb begin
        entry_valid     = 1'b0;
        entry_val1      = '0;
        entry_val2      = '0;
        entry_st_val    = '0;
        entry_dest      = '0;
        entry_src1      = '0;
        entry_src2_forw = '0;
        entry_exe_cmd   = '0;
        entry_mem_r_en  = 1'b0;
        entry_mem_w_en  = 1'b0;
        entry_wb_en     = 1'b0;
        if (accept) begin
            entry_valid     = 1'b1;
            entry_val1      = reg1;
            entry_val2      = dec_imm_sel ? imm_ext : reg2;
            entry_st_val    = reg2;
            entry_dest      = rd_field;
            entry_src1      = src1;
            entry_src2_forw = dec_imm_sel ? '0 : src2;
            entry_exe_cmd   = dec_exe_cmd;
            entry_mem_r_en  = dec_mem_r_en;
            entry_mem_w_en  = dec_mem_w_en;
            entry_wb_en     = dec_wb_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid     <= 1'b0;
            out_val1      <= '0;
            out_val2      <= '0;
            out_st_val    <= '0;
            out_dest      <= '0;
            out_src1      <= '0;
            out_src2_forw <= '0;
            out_exe_cmd   <= '0;
            out_mem_r_en  <= 1'b0;
            out_mem_w_en  <= 1'b0;
            out_wb_en     <= 1'b0;
        end else if (out_free) begin
            out_valid     <= entry_valid;
            out_val1      <= entry_val1;
            out_val2      <= entry_val2;
            out_st_val    <= entry_st_val;
            out_dest      <= entry_dest;
            out_src1      <= entry_src1;
            out_src2_forw <= entry_src2_forw;
            out_exe_cmd   <= entry_exe_cmd;
            out_mem_r_en  <= entry_mem_r_en;
            out_mem_w_en  <= entry_mem_w_en;
            out_wb_en     <= entry_wb_en;
        end
    end

    // Saturating count of cycles where a hazard or STALL holds in_ready low.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if ((hazard || (state == ST_STALL)) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: one instance with LOAD_DELAY=1 and one
// with LOAD_DELAY=3, sharing clock, reset, read data, out_ready and flush.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] instruction;
    logic        in_valid3;
    logic [15:0] instruction3;
    logic [15:0] reg1;
    logic [15:0] reg2;
    logic        flush;
    logic        out_ready;

    logic        d1_in_ready, d1_br_taken, d1_out_valid;
    logic [3:0]  d1_src1, d1_src2, d1_out_dest, d1_out_src1, d1_out_src2_forw, d1_out_exe_cmd;
    logic [15:0] d1_out_val1, d1_out_val2, d1_out_st_val, d1_stall_cnt;
    logic        d1_out_mem_r_en, d1_out_mem_w_en, d1_out_wb_en;

    logic        d3_in_ready, d3_br_taken, d3_out_valid;
    logic [3:0]  d3_src1, d3_src2, d3_out_dest, d3_out_src1, d3_out_src2_forw, d3_out_exe_cmd;
    logic [15:0] d3_out_val1, d3_out_val2, d3_out_st_val, d3_stall_cnt;
    logic        d3_out_mem_r_en, d3_out_mem_w_en, d3_out_wb_en;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.LOAD_DELAY(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d1_in_ready),
        .instruction(instruction), .src1(d1_src1), .src2(d1_src2),
        .reg1(reg1), .reg2(reg2), .br_taken(d1_br_taken), .flush(flush),
        .out_valid(d1_out_valid), .out_ready(out_ready),
        .out_val1(d1_out_val1), .out_val2(d1_out_val2), .out_st_val(d1_out_st_val),
        .out_dest(d1_out_dest), .out_src1(d1_out_src1), .out_src2_forw(d1_out_src2_forw),
        .out_exe_cmd(d1_out_exe_cmd), .out_mem_r_en(d1_out_mem_r_en),
        .out_mem_w_en(d1_out_mem_w_en), .out_wb_en(d1_out_wb_en), .stall_cnt(d1_stall_cnt)
    );

    id_stage_pipe #(.LOAD_DELAY(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(d3_in_ready),
        .instruction(instruction3), .src1(d3_src1), .src2(d3_src2),
        .reg1(reg1), .reg2(reg2), .br_taken(d3_br_taken), .flush(flush),
        .out_valid(d3_out_valid), .out_ready(out_ready),
        .out_val1(d3_out_val1), .out_val2(d3_out_val2), .out_st_val(d3_out_st_val),
        .out_dest(d3_out_dest), .out_src1(d3_out_src1), .out_src2_forw(d3_out_src2_forw),
        .out_exe_cmd(d3_out_exe_cmd), .out_mem_r_en(d3_out_mem_r_en),
        .out_mem_w_en(d3_out_mem_w_en), .out_wb_en(d3_out_wb_en), .stall_cnt(d3_stall_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] instr,
                                 input logic [15:0] r1, input logic [15:0] r2);
        in_valid    = v;
        instruction = instr;
        reg1        = r1;
        reg2        = r2;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lows;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_valid3 = 1'b0; instruction3 = 16'h0000;
        applyStimulus(1'b0, 16'h0000, 16'h0000, 16'h0000);
        tick(); tick();
        checkOutput("rst_out_valid", d1_out_valid, 0);
        checkOutput("rst_stall_cnt", d1_stall_cnt, 0);
        rst = 1'b0;

        // ADD r3,r2: reg1=5, reg2=7
        applyStimulus(1'b1, 16'h1320, 16'd5, 16'd7);
        checkOutput("add_in_ready", d1_in_ready, 1);
        checkOutput("add_src1", d1_src1, 3);
        checkOutput("add_src2", d1_src2, 2);
        checkOutput("add_br", d1_br_taken, 0);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 16'h0000);
        checkOutput("add_valid", d1_out_valid, 1);
        checkOutput("add_val1", d1_out_val1, 16'd5);
        checkOutput("add_val2", d1_out_val2, 16'd7);
        checkOutput("add_dest", d1_out_dest, 3);
        checkOutput("add_wb", d1_out_wb_en, 1);
        checkOutput("add_exe", d1_out_exe_cmd, 1);
        checkOutput("add_src2_forw", d1_out_src2_forw, 2);

        // ADDI r4,#0xFE sign-extends to 0xFFFE
        applyStimulus(1'b1, 16'h84FE, 16'd1, 16'h1234);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 16'h0000);
        checkOutput("addi_val2", d1_out_val2, 16'hFFFE);
        checkOutput("addi_src2_forw", d1_out_src2_forw, 0);
        checkOutput("addi_src1", d1_out_src1, 4);
        checkOutput("addi_wb", d1_out_wb_en, 1);

        // Branch resolution
        applyStimulus(1'b1, 16'hC100, 16'd4, 16'd4);
        checkOutput("bne_eq_br", d1_br_taken, 0);
        checkOutput("bne_src2", d1_src2, 1);
        applyStimulus(1'b1, 16'hC100, 16'd4, 16'd9);
        checkOutput("bne_ne_br", d1_br_taken, 1);
        applyStimulus(1'b1, 16'hB100, 16'd0, 16'd3);
        checkOutput("bez_zero_br", d1_br_taken, 1);
        applyStimulus(1'b1, 16'hB100, 16'd2, 16'd3);
        checkOutput("bez_nonzero_br", d1_br_taken, 0);
        applyStimulus(1'b1, 16'hD000, 16'd2, 16'd3);
        checkOutput("jmp_br", d1_br_taken, 1);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 16'h0000);
        tick();
        checkOutput("bubble_valid", d1_out_valid, 0);

        // Load-use with LOAD_DELAY=1: LD r2 then ADD r5,r2
        applyStimulus(1'b1, 16'h9204, 16'd100, 16'd0);
        tick();
        checkOutput("ld_mem_r", d1_out_mem_r_en, 1);
        checkOutput("ld_dest", d1_out_dest, 2);
        applyStimulus(1'b1, 16'h1520, 16'd3, 16'd4);
        checkOutput("hz1_in_ready", d1_in_ready, 0);
        tick();
        checkOutput("hz1_bubble", d1_out_valid, 0);
        checkOutput("hz1_stall_cnt", d1_stall_cnt, 1);
        checkOutput("hz1_release", d1_in_ready, 1);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 16'h0000);
        checkOutput("hz1_add_valid", d1_out_valid, 1);
        checkOutput("hz1_add_dest", d1_out_dest, 5);
        checkOutput("hz1_add_forw", d1_out_src2_forw, 2);
        checkOutput("hz1_add_val1", d1_out_val1, 16'd3);

        // Load-use with LOAD_DELAY=3
        in_valid3 = 1'b1; instruction3 = 16'h9204; #1;
        tick();
        instruction3 = 16'h1520; #1;
        lows = 0;
        for (int i = 0; i < 10 && !d3_in_ready; i++) begin
            lows++;
            checkOutput("hz3_bubble", d3_out_valid, (lows == 1) ? 1 : 0);
            tick();
        end
        checkOutput("hz3_low_cycles", lows, 3);
        checkOutput("hz3_stall_cnt", d3_stall_cnt, 3);
        tick();
        in_valid3 = 1'b0; #1;
        checkOutput("hz3_add_valid", d3_out_valid, 1);
        checkOutput("hz3_add_dest", d3_out_dest, 5);

        // Backpressure: hold out_ready low for three cycles
        applyStimulus(1'b1, 16'h1320, 16'd5, 16'd7);
        tick();
        out_ready = 1'b0;
        applyStimulus(1'b1, 16'h8101, 16'd11, 16'd0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_in_ready", d1_in_ready, 0);
            checkOutput("bp_valid", d1_out_valid, 1);
            checkOutput("bp_val1", d1_out_val1, 16'd5);
            tick();
        end
        checkOutput("bp_stall_cnt", d1_stall_cnt, 1);
        out_ready = 1'b1; #1;
        checkOutput("bp_release", d1_in_ready, 1);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 16'h0000);
        checkOutput("bp_val1_new", d1_out_val1, 16'd11);
        checkOutput("bp_val2_new", d1_out_val2, 16'd1);
        checkOutput("bp_dest_new", d1_out_dest, 1);

        // Flush while LOAD_DELAY=3 instance is mid-stall
        in_valid3 = 1'b1; instruction3 = 16'h9204; #1;
        tick();
        instruction3 = 16'h1520; #1;
        tick();
        flush = 1'b1; #1;
        tick();
        flush = 1'b0; #1;
        checkOutput("fl3_in_ready", d3_in_ready, 1);
        checkOutput("fl3_valid", d3_out_valid, 0);
        checkOutput("fl3_stall_cnt", d3_stall_cnt, 5);
        tick();
        in_valid3 = 1'b0; #1;
        checkOutput("fl3_add_valid", d3_out_valid, 1);

        // Flush coinciding with an accepted JMP
        flush = 1'b1;
        applyStimulus(1'b1, 16'hD000, 16'd0, 16'd0);
        checkOutput("fl_jmp_br", d1_br_taken, 1);
        tick();
        flush = 1'b0;
        applyStimulus(1'b0, 16'h0000, 16'h0000, 16'h0000);
        checkOutput("fl_jmp_dropped", d1_out_valid, 0);

        // Reset while an entry is valid
        applyStimulus(1'b1, 16'h1320, 16'd5, 16'd7);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 16'h0000);
        checkOutput("pre_rst_valid", d1_out_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        checkOutput("rst2_valid", d1_out_valid, 0);
        checkOutput("rst2_val1", d1_out_val1, 0);
        checkOutput("rst2_stall1", d1_stall_cnt, 0);
        checkOutput("rst2_stall3", d3_stall_cnt, 0);
        checkOutput("rst2_in_ready", d3_in_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
